// File: rtl/trigger_stamper.sv
// trigger_stamper: edge-detects the filtered trigger, applies a programmable
// dead-time, timestamps each accepted trigger with a free-running counter and
// queues the events in a show-ahead FIFO drained through a valid/ready handshake.
//
// Ports:
//   clkf_i      filter clock, all logic on posedge
//   rst_i       asynchronous active-high reset
//   trig_i      filtered trigger, synchronous to clkf_i
//   enable_i    1 = accept triggers, 0 = ignore edges (readout continues)
//   deadtime_i  dead-time in clkf_i cycles after an accepted edge
//   ev_data_o   head event {flags[7:0], ts[TS_W-1:0]}, valid while ev_valid_o=1
//   ev_valid_o  FIFO not empty
//   ev_ready_i  consumer pop, transfer when ev_valid_o & ev_ready_i
//   count_o     accepted triggers (including those dropped on full), wraps
//   drop_o      accepted triggers lost to a full FIFO, saturating
//   level_o     FIFO occupancy 0..DEPTH
//
// Optional feature macro: TRIG_PILEUP_FLAG_EN
//   Defined: edges seen during dead-time are counted (7-bit, saturating) and the
//   count is stored in flags[7:1] of the next accepted event. Undefined: flags[7:1]=0.

module trigger_stamper #(
    parameter int unsigned TS_W  = 24,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clkf_i,
    input  logic              rst_i,
    input  logic              trig_i,
    input  logic              enable_i,
    input  logic [15:0]       deadtime_i,
    output logic [TS_W+7:0]   ev_data_o,
    output logic              ev_valid_o,
    input  logic              ev_ready_i,
    output logic [31:0]       count_o,
    output logic [15:0]       drop_o,
    output logic [AW:0]       level_o
);

    localparam int unsigned EW = TS_W + 8;

    typedef enum logic {IDLE, DEAD} state_t;

    state_t            state_q;
    logic              trig_q;
    logic [TS_W-1:0]   ts_q;
    logic              wrap_q;
    logic [15:0]       dcnt_q;
    logic [31:0]       count_q;
    logic [15:0]       drop_q;
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [AW:0]       level_q;
    logic              valid_q;
    logic [EW-1:0]     head_q;
    logic [EW-1:0]     mem [DEPTH];
    logic [6:0]        pile_c;

    logic              edge_c;
    logic              wrap_now_c;
    logic              accept_c;
    logic              pop_c;
    logic              push_c;
    logic [EW-1:0]     ev_word_c;
    logic [AW-1:0]     rd_d;
    logic [AW:0]       level_d;
    logic [EW-1:0]     head_d;

`ifdef TRIG_PILEUP_FLAG_EN
    logic [6:0]        pile_q;

    // Count edges that arrive during dead-time; handed to the next accepted event.
    always_ff @(posedge clkf_i or posedge rst_i) begin
        if (rst_i) begin
            pile_q <= 7'd0;
        end else if (accept_c) begin
            pile_q <= 7'd0;
        end else if (edge_c && (state_q == DEAD) && (pile_q != 7'h7F)) begin
            pile_q <= pile_q + 7'd1;
        end
    end

    assign pile_c = pile_q;
`else
    assign pile_c = 7'd0;
`endif

    // Event acceptance and FIFO bookkeeping for this cycle.
    always_comb begin
        edge_c     = trig_i & ~trig_q;
        wrap_now_c = (ts_q == {TS_W{1'b1}});
        accept_c   = edge_c & enable_i & (state_q == IDLE);
        pop_c      = valid_q & ev_ready_i;
        // A pop in the same cycle frees a slot even when the FIFO is full.
        push_c     = accept_c & ((level_q != (AW+1)'(DEPTH)) | pop_c);
        ev_word_c  = {pile_c, wrap_q | wrap_now_c, ts_q};
        rd_d       = pop_c ? rd_q + AW'(1) : rd_q;
        level_d    = level_q;
        case ({push_c, pop_c})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
        // Bypass: an event pushed into an otherwise empty FIFO becomes the head.
        head_d = (push_c && (rd_d == wr_q)) ? ev_word_c : mem[rd_d];
    end

    // Event storage (not reset; pointers define what is valid).
    always_ff @(posedge clkf_i) begin
        if (push_c) begin
            mem[wr_q] <= ev_word_c;
        end
    end

    // Timestamp, dead-time FSM, counters and FIFO pointers.
    always_ff @(posedge clkf_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            trig_q  <= 1'b0;
            ts_q    <= '0;
            wrap_q  <= 1'b0;
            dcnt_q  <= 16'd0;
            count_q <= 32'd0;
            drop_q  <= 16'd0;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            valid_q <= 1'b0;
            head_q  <= '0;
        end else begin
            trig_q <= trig_i;
            ts_q   <= ts_q + TS_W'(1);
            // Wrap flag survives a dropped event so the next stored one reports it.
            wrap_q <= push_c ? 1'b0 : (wrap_q | wrap_now_c);

            case (state_q)
                IDLE: begin
                    // Dead-time of 0 or 1 needs no DEAD cycles given 2-cycle edge spacing.
                    if (accept_c && (deadtime_i > 16'd1)) begin
                        state_q <= DEAD;
                        dcnt_q  <= deadtime_i - 16'd1;
                    end
                end
                DEAD: begin
                    dcnt_q <= dcnt_q - 16'd1;
                    if (dcnt_q == 16'd1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (accept_c) begin
                count_q <= count_q + 32'd1;
                if (!push_c && (drop_q != 16'hFFFF)) begin
                    drop_q <= drop_q + 16'd1;
                end
            end

            if (push_c) begin
                wr_q <= wr_q + AW'(1);
            end
            rd_q    <= rd_d;
            level_q <= level_d;
            valid_q <= (level_d != '0);
            head_q  <= head_d;
        end
    end

    assign ev_data_o  = head_q;
    assign ev_valid_o = valid_q;
    assign count_o    = count_q;
    assign drop_o     = drop_q;
    assign level_o    = level_q;

endmodule

// File: tb/tb_trigger_stamper.sv
// Self-checking bench for trigger_stamper (TS_W=8 so the timestamp wraps quickly).
// Every cycle the DUT outputs are compared against an event-queue reference model.
module tb_trigger_stamper;

    localparam int unsigned TS_W  = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = 4;

    logic              clkf_i = 1'b0;
    logic              rst_i  = 1'b1;
    logic              trig_i = 1'b0;
    logic              enable_i = 1'b1;
    logic [15:0]       deadtime_i = 16'd0;
    logic [TS_W+7:0]   ev_data_o;
    logic              ev_valid_o;
    logic              ev_ready_i = 1'b1;
    logic [31:0]       count_o;
    logic [15:0]       drop_o;
    logic [AW:0]       level_o;

    trigger_stamper #(.TS_W(TS_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clkf_i     (clkf_i),
        .rst_i      (rst_i),
        .trig_i     (trig_i),
        .enable_i   (enable_i),
        .deadtime_i (deadtime_i),
        .ev_data_o  (ev_data_o),
        .ev_valid_o (ev_valid_o),
        .ev_ready_i (ev_ready_i),
        .count_o    (count_o),
        .drop_o     (drop_o),
        .level_o    (level_o)
    );

    always #5 clkf_i = ~clkf_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int            n;          // cycles since reset release == absolute timestamp
    int            next_ok;    // first cycle in which an edge may be accepted
    int            last_s;     // cycle of the last stored event (-1 = none)
    bit            prev_t;
    logic [31:0]   m_count;
    int            m_drop;
    int            m_pile;
    logic [15:0]   m_q[$];

    // Drive values used by step()
    bit            en  = 1'b1;
    logic [15:0]   dt  = 16'd0;
    bit            rdy = 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, n, got, exp);
        end
    endtask

    task automatic model_reset();
        n = 0; next_ok = 0; last_s = -1; prev_t = 1'b0;
        m_count = 32'd0; m_drop = 0; m_pile = 0;
        m_q.delete();
    endtask

    // Called at posedge+1: compare outputs, apply inputs for one cycle, advance model.
    task automatic step(input bit t);
        bit   edge_s, pop;
        int   sz;
        bit   wflag;
        logic [6:0] pl;
        check("valid", 32'(ev_valid_o), 32'(m_q.size() != 0));
        check("level", 32'(level_o), 32'(m_q.size()));
        check("count", count_o, m_count);
        check("drop",  32'(drop_o), 32'(m_drop));
        if (m_q.size() != 0) check("data", 32'(ev_data_o), 32'(m_q[0]));

        trig_i = t; enable_i = en; deadtime_i = dt; ev_ready_i = rdy;
        edge_s = t & ~prev_t;
        prev_t = t;
        sz  = m_q.size();
        pop = (sz != 0) && rdy;
        if (pop) void'(m_q.pop_front());
        if (edge_s) begin
            if (n >= next_ok) begin
                if (en) begin
                    m_count = m_count + 32'd1;
                    next_ok = n + ((dt == 16'd0) ? 1 : int'(dt));
`ifdef TRIG_PILEUP_FLAG_EN
                    pl = 7'(m_pile);
`else
                    pl = 7'd0;
`endif
                    m_pile = 0;
                    if (sz < int'(DEPTH) || pop) begin
                        // wrap flag: a ts wrap (255->0) happened in (last_s, n]
                        wflag  = ((n + 1) / 256) > ((last_s + 1) / 256);
                        last_s = n;
                        m_q.push_back({pl, wflag, 8'(n % 256)});
                    end else if (m_drop < 65535) begin
                        m_drop++;
                    end
                end
            end else if (m_pile < 127) begin
                m_pile++;
            end
        end
        @(posedge clkf_i); #1;
        n++;
    endtask

    task automatic hold(input int k, input bit t);
        for (int i = 0; i < k; i++) step(t);
    endtask

    // Asynchronous reset pulse entered at posedge+1; outputs must clear before any edge.
    task automatic do_reset();
        trig_i = 1'b0;
        rst_i  = 1'b1;
        #1;
        check("rst_valid", 32'(ev_valid_o), 32'd0);
        check("rst_data",  32'(ev_data_o),  32'd0);
        check("rst_count", count_o,         32'd0);
        check("rst_drop",  32'(drop_o),     32'd0);
        check("rst_level", 32'(level_o),    32'd0);
        #1;
        rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        @(posedge clkf_i); #1;

        // 1: single 3-cycle pulse at ts=100, deadtime 0
        do_reset();
        en = 1; dt = 16'd0; rdy = 1;
        hold(100, 0); hold(3, 1); hold(6, 0);

        // 2: deadtime 10, edges at 20,25,30,32 -> only 20 and 30 accepted
        @(posedge clkf_i); #1;
        do_reset();
        dt = 16'd10; rdy = 0;
        hold(20, 0); step(1); hold(4, 0); step(1); hold(4, 0); step(1); step(0); step(1);
        hold(4, 0);
        check("t2_count", count_o, 32'd2);
        rdy = 1; hold(4, 0);

        // 3: ready low, 20 edges spaced 4 -> 16 stored, 4 dropped, then drain
        do_reset();
        dt = 16'd0; rdy = 0;
        for (int i = 0; i < 20; i++) begin step(1); hold(3, 0); end
        check("t3_level", 32'(level_o), 32'd16);
        check("t3_drop",  32'(drop_o),  32'd4);
        rdy = 1; hold(20, 0);
        check("t3_empty", 32'(ev_valid_o), 32'd0);

        // 4: full FIFO, edge coinciding with a pop -> no drop
        do_reset();
        rdy = 0;
        for (int i = 0; i < 16; i++) begin step(1); step(0); end
        rdy = 1; step(1); rdy = 0; hold(3, 0);
        check("t4_level", 32'(level_o), 32'd16);
        check("t4_drop",  32'(drop_o),  32'd0);
        rdy = 1; hold(18, 0);

        // 5: edge at ts=250 then ts=5 after the wrap -> second event flags[0]=1
        do_reset();
        rdy = 0;
        hold(250, 0); step(1); hold(10, 0); step(1); hold(3, 0);
        rdy = 1; hold(4, 0);

        // 6: reset mid-dead-time with 5 events buffered, edge right after release
        do_reset();
        rdy = 0; dt = 16'd3;
        for (int i = 0; i < 4; i++) begin step(1); hold(3, 0); end
        dt = 16'd50; step(1); hold(10, 0);
        check("t6_level", 32'(level_o), 32'd5);
        do_reset();
        rdy = 1; dt = 16'd0;
        step(1); hold(4, 0);
        check("t6_count", count_o, 32'd1);

        // Randomized traffic with varying ready pressure, enable and dead-time
        do_reset();
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 500; i++) begin
                if (i % 40 == 0) dt = 16'($urandom_range(0, 12));
                en  = ($urandom % 8) != 0;
                rdy = ($urandom % 4) < ((blk % 3) + 1);
                step(1'($urandom % 2));
            end
        end
        rdy = 1; hold(20, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
